pwm_led_driver: RTL
===================

# pwm_led_driver

Single-channel PWM generator that turns an 8-bit level from the ramp stage into a pulse train driving an LED. The level is captured into a shadow register and applied only at PWM period boundaries, so the output never glitches mid-period. A one-cycle `period_tick` strobe marks each boundary; it is intended to drive the ramp stage's `enable`, so the ramp advances exactly one step per PWM period.

## Interface
- `WIDTH`, 8: duty/counter width in bits; the period is 2^WIDTH−1 count ticks.
- `PRESCALE_DIV`, 4: clk cycles per count tick; must be ≥1.
- `ACTIVE_LOW`, 0: when 1, `pwm_out` is inverted (LED sinks current).

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  run; low freezes all counters and forces `pwm_out` inactive.
- `duty`  in  WIDTH  requested duty level from the ramp stage.
- `duty_load`  in  1  capture `duty` into the shadow register this cycle.
- `pwm_out`  out  1  registered PWM output.
- `period_tick`  out  1  one-cycle pulse at each period boundary.
- `duty_active`  out  WIDTH  duty value currently in use.

## Operation
- Prescaler `pre` counts 0..PRESCALE_DIV−1 while `enable`=1 and wraps to 0. Internal `tick` = `enable` && `pre`==PRESCALE_DIV−1. With PRESCALE_DIV=1, `tick`=`enable`.
- Period counter `cnt` counts 0..2^WIDTH−2 and advances on `tick`. `boundary` = `tick` && `cnt`==2^WIDTH−2; on `boundary`, `cnt` wraps to 0.
- Shadow register and flag:
  - When `duty_load`=1, `shadow`<=`duty` and `pending`<=1.
  - Loads are accepted regardless of `enable`.
  - The last load before a boundary wins.
- On `boundary`:
  - If `duty_load`=1 in the same cycle, `duty_active`<=`duty` (bypass).
  - Otherwise, if `pending`=1, `duty_active`<=`shadow`.
  - `pending` clears in both cases.
- Compare: `pwm_out` <= (`enable` && `cnt` < `duty_active`) XOR ACTIVE_LOW, registered every clk.
  - `duty`=0 gives always inactive.
  - `duty`=2^WIDTH−1 gives always active (100 %).
  - The duty fraction is `duty_active`/(2^WIDTH−1).
- `period_tick` <= `boundary`, registered.
- `enable` low:
  - `pre` and `cnt` hold their values.
  - `pwm_out` goes inactive on the next clk.
  - `period_tick`=0.
  - On re-enable, counting resumes from the held values; nothing restarts.
- No states beyond the counters; there is no explicit FSM.

## Timing
- Reset values:
  - `pre`=0, `cnt`=0, `shadow`=0, `pending`=0.
  - `duty_active`=0, `period_tick`=0.
  - `pwm_out`=ACTIVE_LOW (inactive level).
- Reset mid-period aborts the period immediately; the first post-reset period is a full period.
- Latency:
  - `pwm_out` lags the `cnt`/`duty_active` state by 1 clk.
  - `period_tick` is high in the clk after the wrap.
  - `duty_active` updates in the clk after `boundary`.
- Period length = PRESCALE_DIV × (2^WIDTH−1) clks; defaults give 1020.
- A duty value loaded at any time becomes visible on `pwm_out` at the start of the next period, never sooner.

## Structure
- Shared package `pwm_pkg`:
  - default WIDTH and PRESCALE_DIV constants;
  - function `pwm_cnt_max(width)` returning 2^width−2;
  - inactive-level helper for ACTIVE_LOW.
- Sub-module `clk_prescaler` (parameter DIV; ports `clk`, `reset`, `enable`, `tick`). The top holds the period counter, shadow logic, compare and output registers.

## Test plan
- Reset then `duty`=128 loaded, PRESCALE_DIV=1 → from the 2nd period onward, `pwm_out` high 128 clks, low 127 clks, period 255 clks; `period_tick` exactly once per 255 clks.
- `duty`=0 and `duty`=255 across 3 periods each → `pwm_out` constant 0 and constant 1 respectively, with no single-cycle glitch at boundaries.
- Load `duty`=200 at `cnt`=50, then load 10 at `cnt`=100 within the same period → current period unchanged; next period uses 10; `duty_active` changes exactly 1 clk after `boundary`.
- `duty_load`=1 with `duty`=77 in the boundary cycle → next period uses 77 (bypass), `pending`=0 afterward.
- `enable` deasserted for 40 clks at `cnt`=30 → `pwm_out` inactive, no `period_tick`, `cnt` held at 30; resumes from 30; that period takes 295 clks total.
- ACTIVE_LOW=1, PRESCALE_DIV=4, `duty`=64 → `pwm_out` low 256 clks then high 764 clks per 1020-clk period; `reset` asserted mid-period → `pwm_out`=1 and `duty_active`=0 on the next clk.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and helpers for the PWM LED driver slice
package pwm_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_PRESCALE_DIV = 4;
  function automatic int pwm_cnt_max(input int width);
    return (1 << width) - 2;
  endfunction
  function automatic logic pwm_inactive(input bit active_low);
    return active_low;
  endfunction
endpackage

// File: rtl/pwm_led_driver_if.sv
// pwm_led_driver_if: control/status bundle between ramp stage and PWM driver
interface pwm_led_driver_if #(parameter int WIDTH = 8);
  logic enable;
  logic duty_load;
  logic [WIDTH-1:0] duty;
  logic pwm_out;
  logic period_tick;
  logic [WIDTH-1:0] duty_active;
  modport master(output enable, duty_load, duty, input pwm_out, period_tick, duty_active);
  modport slave(input enable, duty_load, duty, output pwm_out, period_tick, duty_active);
endinterface

// File: rtl/clk_prescaler.sv
// clk_prescaler: one-cycle tick every DIV enabled clocks; holds its count while disabled
module clk_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  logic [PW-1:0] pre;
  assign tick = enable && pre == PW'(DIV - 1);
  always_ff @(posedge clk) begin
    if (reset) pre <= '0;
    else if (enable) pre <= tick ? '0 : pre + PW'(1);
  end
endmodule

// File: rtl/pwm_led_driver.sv
// pwm_led_driver: glitch-free PWM whose duty is shadowed and applied only at period boundaries
module pwm_led_driver
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic clk,
  input logic reset,
  pwm_led_driver_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(pwm_cnt_max(WIDTH));
  logic tick, boundary, pending, pwm_out, period_tick;
  logic [WIDTH-1:0] cnt, shadow, duty_active;
  clk_prescaler #(.DIV(PRESCALE_DIV)) u_prescaler (
    .clk(clk),
    .reset(reset),
    .enable(bus.enable),
    .tick(tick)
  );
  assign boundary = tick && cnt == CNT_MAX;
  // a load coinciding with the boundary bypasses the shadow so it is not lost
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      shadow <= '0;
      pending <= 1'b0;
      duty_active <= '0;
      period_tick <= 1'b0;
      pwm_out <= pwm_inactive(ACTIVE_LOW);
    end else begin
      if (tick) cnt <= boundary ? '0 : cnt + WIDTH'(1);
      if (bus.duty_load) shadow <= bus.duty;
      if (boundary) duty_active <= bus.duty_load ? bus.duty : pending ? shadow : duty_active;
      pending <= boundary ? 1'b0 : bus.duty_load | pending;
      period_tick <= boundary;
      pwm_out <= (bus.enable && cnt < duty_active) ^ ACTIVE_LOW;
    end
  end
  assign bus.pwm_out = pwm_out;
  assign bus.period_tick = period_tick;
  assign bus.duty_active = duty_active;
endmodule
